ciq_alloc: RTL and testbench

//  Allocation stage directly upstream of the 16-entry centralised issue queue.

---
 rtl/ciq_alloc_if.sv | 25 ++
 rtl/ciq_alloc.sv | 83 ++++++++
 tb/tb_ciq_alloc.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ciq_alloc_if.sv
// ciq_alloc_if: rename dispatch, CIQ write port and arbiter release signals of the CIQ allocator
interface ciq_alloc_if #(
    parameter int INSTR_NUM = 4,
    parameter int ISSUE_NUM = 4,
    parameter int ADDR_W    = 4,
    parameter int AGE       = 5
);
    logic                                flush;
    logic [INSTR_NUM-1:0]                dispatch_valid;
    logic                                dispatch_ready;
    logic [INSTR_NUM-1:0][ADDR_W-1:0]    free_addr;
    logic [INSTR_NUM-1:0]                free_valid;
    logic [INSTR_NUM-1:0][AGE-1:0]       age;
    logic [ISSUE_NUM-1:0][ADDR_W-1:0]    arbit_addr;
    logic [ISSUE_NUM-1:0]                arbit_grant;
    logic [ADDR_W:0]                     free_count;
    modport master (
        output flush, dispatch_valid, arbit_addr, arbit_grant,
        input  dispatch_ready, free_addr, free_valid, age, free_count
    );
    modport slave (
        input  flush, dispatch_valid, arbit_addr, arbit_grant,
        output dispatch_ready, free_addr, free_valid, age, free_count
    );
endinterface

// File: rtl/ciq_alloc.sv
// ciq_alloc: free-entry tracker and all-or-nothing allocator for the issue queue; CIQ_ALLOC_PERF_EN adds stall_cnt
module ciq_alloc #(
    parameter int INSTR_NUM = 4,
    parameter int ISSUE_NUM = 4,
    parameter int CIQ_DEPTH = 16,
    parameter int ADDR_W    = 4,
    parameter int AGE       = 5
) (
    input logic        clk,
    input logic        rst,
    ciq_alloc_if.slave bus
`ifdef CIQ_ALLOC_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam int IDX_W = $clog2(INSTR_NUM);
    logic [CIQ_DEPTH-1:0]             free_vec, rel_mask, alloc_mask;
    logic [AGE-1:0]                   age_ctr;
    logic [ADDR_W:0]                  n_free, n_req;
    logic [INSTR_NUM-1:0][ADDR_W-1:0] sel;
    logic [IDX_W-1:0]                 rank;
    logic                             ready;
    assign bus.dispatch_ready = ready;
    assign bus.free_count     = rst ? (ADDR_W+1)'(CIQ_DEPTH) : n_free;
    // count free entries and list the lowest INSTR_NUM of them in index order
    always_comb begin
        sel    = '0;
        n_free = '0;
        for (int e = 0; e < CIQ_DEPTH; e++)
            if (free_vec[e]) begin
                if (n_free < (ADDR_W+1)'(INSTR_NUM)) sel[n_free[IDX_W-1:0]] = ADDR_W'(e);
                n_free = n_free + (ADDR_W+1)'(1);
            end
    end
    // accept the whole group or nothing; each valid slot takes the free entry matching its rank
    always_comb begin
        n_req = '0;
        for (int i = 0; i < INSTR_NUM; i++) n_req = n_req + (ADDR_W+1)'(bus.dispatch_valid[i]);
        ready          = !rst && !bus.flush && (n_free >= n_req);
        rank           = '0;
        alloc_mask     = '0;
        bus.free_valid = '0;
        bus.free_addr  = '0;
        bus.age        = '0;
        for (int i = 0; i < INSTR_NUM; i++) begin
            if (bus.dispatch_valid[i] && ready) begin
                bus.free_valid[i]     = 1'b1;
                bus.free_addr[i]      = sel[rank];
                bus.age[i]            = age_ctr + AGE'(rank);
                alloc_mask[sel[rank]] = 1'b1;
            end
            rank = rank + IDX_W'(bus.dispatch_valid[i]);
        end
    end
    // entries handed back by the arbiter; duplicate addresses simply OR together
    always_comb begin
        rel_mask = '0;
        for (int j = 0; j < ISSUE_NUM; j++)
            if (bus.arbit_grant[j]) rel_mask[bus.arbit_addr[j]] = 1'b1;
    end
    // pool and age counter update; allocation beats a same-cycle release of the same entry
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            free_vec <= '1;
            age_ctr  <= '0;
        end else begin
            free_vec <= (free_vec | rel_mask) & ~alloc_mask;
            if (ready) age_ctr <= age_ctr + AGE'(n_req);
        end
    end
    // releasing an entry that is already free points at an arbiter bug
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) assert ((rel_mask & free_vec & ~alloc_mask) == '0);
    end
`ifdef CIQ_ALLOC_PERF_EN
    // saturating count of cycles where rename had work but was held off
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (n_req != '0 && !ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ciq_alloc.sv
// tb_ciq_alloc: directed and random checks of ciq_alloc against a free-list reference model
module tb_ciq_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ciq_alloc_if bus ();
`ifdef CIQ_ALLOC_PERF_EN
    logic [15:0] stall_cnt;
`endif
    ciq_alloc dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CIQ_ALLOC_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );
    bit              mfree[16];
    int              mage;
    int              n_cmp, n_bad;
    int              alloc_q[$];
    logic [3:0]      prev_g;
    logic [3:0][3:0] prev_ga;
    logic            obs_rdy;
    logic [3:0]      obs_fv;
    logic [15:0]     obs_addr;
    logic [19:0]     obs_age;
    logic [4:0]      obs_cnt;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic rs, input logic [3:0] dv, input logic fl,
                        input logic [3:0] g, input logic [3:0][3:0] ga);
        int nreq, nf, r;
        int fq[$];
        bit rdy;
        logic [3:0]  efv;
        logic [15:0] eaddr, amask;
        logic [19:0] eage, gmask;
        @(negedge clk);
        rst = rs;
        bus.dispatch_valid = dv;
        bus.flush = fl;
        bus.arbit_grant = g;
        bus.arbit_addr = ga;
        #2;
        nreq = $countones(dv);
        nf = 0;
        for (int e = 0; e < 16; e++) if (mfree[e]) begin nf++; fq.push_back(e); end
        rdy = !rs && !fl && nf >= nreq;
        efv = 0; eaddr = 0; amask = 0; eage = 0; gmask = 0; r = 0;
        alloc_q.delete();
        for (int i = 0; i < 4; i++) begin
            if (!dv[i] || rs) begin
                amask[i*4+:4] = 4'hF;
                gmask[i*5+:5] = 5'h1F;
            end else if (rdy) begin
                efv[i] = 1'b1;
                amask[i*4+:4] = 4'hF;
                gmask[i*5+:5] = 5'h1F;
                eaddr[i*4+:4] = 4'(fq[r]);
                eage[i*5+:5] = 5'((mage + r) % 32);
                alloc_q.push_back(fq[r]);
            end
            if (dv[i]) r++;
        end
        obs_rdy = bus.dispatch_ready;
        obs_fv = bus.free_valid;
        obs_addr = bus.free_addr;
        obs_age = bus.age;
        obs_cnt = bus.free_count;
        chk("dispatch_ready", 32'(obs_rdy), 32'(rdy));
        chk("free_valid", 32'(obs_fv), 32'(efv));
        chk("free_addr", 32'(obs_addr & amask), 32'(eaddr));
        chk("age", 32'(obs_age & gmask), 32'(eage));
        chk("free_count", 32'(obs_cnt), rs ? 32'd16 : 32'(nf));
        @(posedge clk);
        if (rs || fl) begin
            foreach (mfree[e]) mfree[e] = 1'b1;
            mage = 0;
        end else begin
            for (int j = 0; j < 4; j++) if (g[j]) mfree[ga[j]] = 1'b1;
            foreach (alloc_q[k]) mfree[alloc_q[k]] = 1'b0;
            if (rdy) mage = (mage + nreq) % 32;
        end
        prev_g = '0;
        prev_ga = '0;
        foreach (alloc_q[k]) begin
            prev_g[k] = 1'b1;
            prev_ga[k] = 4'(alloc_q[k]);
        end
    endtask
    initial begin
        logic [3:0]      g;
        logic [3:0][3:0] ga;
        int q[$];
        n_cmp = 0;
        n_bad = 0;
        foreach (mfree[e]) mfree[e] = 1'b1;
        mage = 0;
        bus.dispatch_valid = '0;
        bus.flush = 1'b0;
        bus.arbit_grant = '0;
        bus.arbit_addr = '0;
        repeat (2) @(posedge clk);
        step(1, 4'hF, 0, 0, 0);
        chk("reset_ready", 32'(obs_rdy), 32'd0);
        // first full group after reset
        step(0, 4'hF, 0, 0, 0);
        chk("t1_addr", 32'(obs_addr), 32'h3210);
        chk("t1_age", 32'(obs_age), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
        // fill the queue, then a fifth group must stall
        repeat (3) step(0, 4'hF, 0, 0, 0);
        chk("t1_cnt_after", 32'(obs_cnt), 32'd4);
        step(0, 4'hF, 0, 0, 0);
        chk("t2_full_ready", 32'(obs_rdy), 32'd0);
        chk("t2_full_cnt", 32'(obs_cnt), 32'd0);
        step(0, 4'h0, 0, 4'b0011, {4'd0, 4'd0, 4'd9, 4'd5});
        step(0, 4'b0111, 0, 0, 0);
        chk("t2_cnt2", 32'(obs_cnt), 32'd2);
        chk("t2_stall3", 32'(obs_fv), 32'd0);
        step(0, 4'b0011, 0, 0, 0);
        chk("t2_pair", 32'(obs_addr), 32'h0095);
        // sparse dispatch pattern
        step(1, 4'hF, 0, 0, 0);
        step(0, 4'hF, 0, 0, 0);
        step(0, 4'b1010, 0, 0, 0);
        chk("t3_addr", 32'(obs_addr), 32'h5040);
        chk("t3_age", 32'(obs_age), 32'({5'd5, 5'd0, 5'd4, 5'd0}));
        step(0, 4'b0001, 0, 0, 0);
        chk("t3_agectr", 32'(obs_age), 32'd6);
        // age counter wrap
        step(1, 4'h0, 0, 0, 0);
        prev_g = '0;
        prev_ga = '0;
        repeat (7) step(0, 4'hF, 0, prev_g, prev_ga);
        step(0, 4'b0011, 0, prev_g, prev_ga);
        step(0, 4'hF, 0, prev_g, prev_ga);
        chk("t4_wrap_age", 32'(obs_age), 32'({5'd1, 5'd0, 5'd31, 5'd30}));
        step(0, 4'b0001, 0, prev_g, prev_ga);
        chk("t4_agectr", 32'(obs_age), 32'd2);
        // same-cycle release and allocation of entry 7
        step(1, 4'h0, 0, 0, 0);
        repeat (4) step(0, 4'hF, 0, 0, 0);
        step(0, 4'h0, 0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd7});
        step(0, 4'b0001, 0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd7});
        chk("t5_addr", 32'(obs_addr), 32'd7);
        step(0, 4'h0, 0, 0, 0);
        chk("t5_cnt", 32'(obs_cnt), 32'd0);
        // flush drops the group and pending grants
        step(1, 4'h0, 0, 0, 0);
        step(0, 4'hF, 0, 0, 0);
        step(0, 4'hF, 1, 4'b0011, {4'd0, 4'd0, 4'd1, 4'd0});
        chk("t6_fv", 32'(obs_fv), 32'd0);
        step(0, 4'hF, 0, 0, 0);
        chk("t6_cnt", 32'(obs_cnt), 32'd16);
        chk("t6_addr", 32'(obs_addr), 32'h3210);
        // random traffic, grants drawn from currently allocated entries
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int e = 0; e < 16; e++) if (!mfree[e]) q.push_back(e);
            g = '0;
            ga = '0;
            for (int j = 0; j < 4; j++)
                if (q.size() > 0 && $urandom_range(1, 0) == 1) begin
                    g[j] = 1'b1;
                    ga[j] = 4'(q[$urandom_range(q.size() - 1, 0)]);
                end
            step(($urandom % 97) == 0, 4'($urandom), ($urandom % 32) == 0, g, ga);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
